// File: rtl/ulpi_reg_seq_pkg.sv
// Shared definitions for the ULPI register sequencer: PHY register
// addresses, the boot table and the sequencer state encoding.
package ulpi_pkg;

  // PHY register addresses used by the sequencer
  localparam logic [5:0] FUNC_CTRL = 6'h04;
  localparam logic [5:0] OTG_CTRL  = 6'h0A;

  // Boot values written to the PHY
  localparam logic [7:0] FUNC_CTRL_RESET = 8'h20;  // PHY reset bit
  localparam logic [7:0] FUNC_CTRL_RUN   = 8'h45;  // FS, TermSelect, SuspendM
  localparam logic [7:0] OTG_CTRL_INIT   = 8'h00;

  // Value the final boot read-back must return
  localparam logic [7:0] BOOT_READ_EXPECT = 8'h45;

  // Index of the last boot step (the read-back)
  localparam logic [1:0] BOOT_LAST_STEP = 2'd3;

  // Bit of FUNC_CTRL that resets the PHY and drops ULPI ready
  localparam int PHY_RESET_BIT = 5;

  typedef struct packed {
    logic       rw;     // 1 = write, 0 = read
    logic [5:0] addr;
    logic [7:0] wdata;
  } boot_step_t;

  typedef enum logic [2:0] {
    WAIT_RDY,
    INIT_ISSUE,
    INIT_WAIT,
    INIT_CHECK,
    IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    FAILED
  } state_t;

  // Boot table lookup: writes first, read-back of FUNC_CTRL last
  function automatic boot_step_t boot_step(input logic [1:0] idx);
    boot_step_t s;
    case (idx)
      2'd0:    s = '{rw: 1'b1, addr: FUNC_CTRL, wdata: FUNC_CTRL_RESET};
      2'd1:    s = '{rw: 1'b1, addr: FUNC_CTRL, wdata: FUNC_CTRL_RUN};
      2'd2:    s = '{rw: 1'b1, addr: OTG_CTRL,  wdata: OTG_CTRL_INIT};
      default: s = '{rw: 1'b0, addr: FUNC_CTRL, wdata: 8'h00};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ulpi_rr_arb.sv
// Two-way round-robin arbiter. The priority pointer names the requester
// that wins a tie; it moves to the other requester after every grant.
module ulpi_rr_arb
  import ulpi_pkg::*;
(
  input  logic       CLK_60M,
  input  logic       RST_USB,
  input  logic [1:0] req_vec,
  output logic       gnt_valid,
  output logic       gnt_id
);

  logic prio_q;

  // Pick the priority holder if it requests, otherwise the other one
  always_comb begin
    gnt_valid = |req_vec;
    gnt_id    = req_vec[prio_q] ? prio_q : ~prio_q;
  end

  // After a grant the requester not just served gets priority
  always_ff @(posedge CLK_60M) begin
    if (RST_USB) begin
      prio_q <= 1'b0;
    end else if (gnt_valid) begin
      prio_q <= ~gnt_id;
    end
  end

endmodule

// File: rtl/ulpi_reg_seq.sv
// ULPI register sequencer: runs the PHY boot table once after reset, then
// serves register accesses from two requesters with round-robin grant.
// Every access is retried on PHY abort or timeout before it is reported
// as an error.
module ulpi_reg_seq
  import ulpi_pkg::*;
#(
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic        CLK_60M,
  input  logic        RST_USB,
  input  logic        ULPI_READY,
  output logic        REG_EN,
  output logic        REG_RW,
  output logic [5:0]  REG_ADDR,
  output logic [7:0]  REG_WDATA,
  input  logic [7:0]  REG_RDATA,
  input  logic        REG_DONE,
  input  logic        REG_FAIL,
  input  logic [1:0]  REQ_EN,
  input  logic [1:0]  REQ_RW,
  input  logic [11:0] REQ_ADDR,
  input  logic [15:0] REQ_WDATA,
  output logic [1:0]  REQ_DONE,
  output logic [1:0]  REQ_ERR,
  output logic [7:0]  REQ_RDATA,
  output logic        INIT_DONE,
  output logic        INIT_ERR
);

  localparam logic [1:0] RETRY_LAST   = 2'(MAX_RETRY - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic       rdy_seen_q;
  logic [1:0] step_q;
  logic [1:0] retry_q;
  logic [7:0] tmo_q;
  logic [7:0] rdata_q;

  logic       cap_id_q;
  logic       cap_rw_q;
  logic [5:0] cap_addr_q;
  logic [7:0] cap_wdata_q;

  boot_step_t cur_step;
  logic       in_wait;
  logic       timed_out;
  logic       acc_ok;
  logic       acc_fail;
  logic       last_try;
  logic       boot_match;
  logic       phy_reset_wr;
  logic [1:0] arb_req;
  logic       gnt_valid;
  logic       gnt_id;

  assign cur_step  = boot_step(step_q);
  assign in_wait   = (state_q == INIT_WAIT) || (state_q == ARB_WAIT);
  assign timed_out = (tmo_q >= TIMEOUT_LAST);
  // A simultaneous DONE and FAIL is an abort, so FAIL wins
  assign acc_ok    = in_wait && REG_DONE && !REG_FAIL;
  assign acc_fail  = in_wait && (REG_FAIL || (!REG_DONE && timed_out));
  assign last_try  = (retry_q >= RETRY_LAST);
  assign boot_match   = (rdata_q == BOOT_READ_EXPECT);
  assign phy_reset_wr = cap_rw_q && (cap_addr_q == FUNC_CTRL) && cap_wdata_q[PHY_RESET_BIT];

  // A requester whose completion pulse is on this cycle has not yet had a
  // chance to drop its level request, so it is masked for one cycle.
  assign arb_req = (state_q == IDLE) ? (REQ_EN & ~(REQ_DONE | REQ_ERR)) : 2'b00;

  ulpi_rr_arb u_rr_arb (
    .CLK_60M   (CLK_60M),
    .RST_USB   (RST_USB),
    .req_vec   (arb_req),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // State register
  always_ff @(posedge CLK_60M) begin
    if (RST_USB) begin
      state_q <= WAIT_RDY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decision for boot, arbitration, retry and error handling
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_RDY: begin
        if (ULPI_READY && rdy_seen_q) begin
          state_d = INIT_DONE ? IDLE : INIT_ISSUE;
        end
      end
      INIT_ISSUE: begin
        if (ULPI_READY) state_d = INIT_WAIT;
      end
      INIT_WAIT: begin
        if (acc_ok) begin
          if (step_q == 2'd0)                state_d = WAIT_RDY;
          else if (step_q == BOOT_LAST_STEP) state_d = INIT_CHECK;
          else                               state_d = INIT_ISSUE;
        end else if (acc_fail) begin
          state_d = last_try ? FAILED : INIT_ISSUE;
        end
      end
      INIT_CHECK: begin
        state_d = boot_match ? IDLE : FAILED;
      end
      IDLE: begin
        if (gnt_valid) state_d = ARB_ISSUE;
      end
      ARB_ISSUE: begin
        if (ULPI_READY) state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (acc_ok) begin
          state_d = phy_reset_wr ? WAIT_RDY : IDLE;
        end else if (acc_fail) begin
          state_d = last_try ? IDLE : ARB_ISSUE;
        end
      end
      FAILED: begin
        state_d = FAILED;
      end
      default: begin
        state_d = WAIT_RDY;
      end
    endcase
  end

  // ULPI-side outputs: the strobe only when ready, the access fields held
  // from the issue cycle until the access ends
  always_comb begin
    REG_EN    = 1'b0;
    REG_RW    = 1'b0;
    REG_ADDR  = 6'h00;
    REG_WDATA = 8'h00;
    unique case (state_q)
      INIT_ISSUE, INIT_WAIT: begin
        REG_EN    = (state_q == INIT_ISSUE) && ULPI_READY;
        REG_RW    = cur_step.rw;
        REG_ADDR  = cur_step.addr;
        REG_WDATA = cur_step.wdata;
      end
      ARB_ISSUE, ARB_WAIT: begin
        REG_EN    = (state_q == ARB_ISSUE) && ULPI_READY;
        REG_RW    = cap_rw_q;
        REG_ADDR  = cap_addr_q;
        REG_WDATA = cap_wdata_q;
      end
      default: begin
        REG_EN = 1'b0;
      end
    endcase
  end

  // Counters, captured request, read data and the registered status pulses
  always_ff @(posedge CLK_60M) begin
    if (RST_USB) begin
      rdy_seen_q  <= 1'b0;
      step_q      <= 2'd0;
      retry_q     <= 2'd0;
      tmo_q       <= 8'h00;
      rdata_q     <= 8'h00;
      cap_id_q    <= 1'b0;
      cap_rw_q    <= 1'b0;
      cap_addr_q  <= 6'h00;
      cap_wdata_q <= 8'h00;
      REQ_DONE    <= 2'b00;
      REQ_ERR     <= 2'b00;
      REQ_RDATA   <= 8'h00;
      INIT_DONE   <= 1'b0;
      INIT_ERR    <= 1'b0;
    end else begin
      REQ_DONE <= 2'b00;
      REQ_ERR  <= 2'b00;

      rdy_seen_q <= (state_q == WAIT_RDY) ? ULPI_READY : 1'b0;

      if (REG_EN) begin
        tmo_q <= 8'h00;
      end else if (in_wait && (tmo_q != 8'hFF)) begin
        tmo_q <= tmo_q + 8'd1;
      end

      if (in_wait) begin
        if (acc_ok) begin
          retry_q <= 2'd0;
        end else if (acc_fail) begin
          retry_q <= last_try ? 2'd0 : retry_q + 2'd1;
        end
      end else if ((state_q != INIT_ISSUE) && (state_q != ARB_ISSUE)) begin
        retry_q <= 2'd0;
      end

      if ((state_q == INIT_WAIT) && acc_ok) begin
        rdata_q <= REG_RDATA;
        if (step_q != BOOT_LAST_STEP) step_q <= step_q + 2'd1;
      end

      if ((state_q == INIT_WAIT) && acc_fail && last_try) begin
        INIT_ERR <= 1'b1;
      end

      if (state_q == INIT_CHECK) begin
        if (boot_match) INIT_DONE <= 1'b1;
        else            INIT_ERR  <= 1'b1;
      end

      if (gnt_valid) begin
        cap_id_q    <= gnt_id;
        cap_rw_q    <= REQ_RW[gnt_id];
        cap_addr_q  <= gnt_id ? REQ_ADDR[11:6] : REQ_ADDR[5:0];
        cap_wdata_q <= gnt_id ? REQ_WDATA[15:8] : REQ_WDATA[7:0];
      end

      if ((state_q == ARB_WAIT) && acc_ok) begin
        REQ_DONE[cap_id_q] <= 1'b1;
        REQ_RDATA          <= cap_rw_q ? 8'h00 : REG_RDATA;
      end

      if ((state_q == ARB_WAIT) && acc_fail && last_try) begin
        REQ_ERR[cap_id_q] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ulpi_reg_seq.sv
// Directed bench for the ULPI register sequencer. The PHY and the two
// requesters are played step by step from a single initial block.
module tb_ulpi_reg_seq;

  logic        CLK_60M = 1'b0;
  logic        RST_USB;
  logic        ULPI_READY;
  logic        REG_EN;
  logic        REG_RW;
  logic [5:0]  REG_ADDR;
  logic [7:0]  REG_WDATA;
  logic [7:0]  REG_RDATA;
  logic        REG_DONE;
  logic        REG_FAIL;
  logic [1:0]  REQ_EN;
  logic [1:0]  REQ_RW;
  logic [11:0] REQ_ADDR;
  logic [15:0] REQ_WDATA;
  logic [1:0]  REQ_DONE;
  logic [1:0]  REQ_ERR;
  logic [7:0]  REQ_RDATA;
  logic        INIT_DONE;
  logic        INIT_ERR;

  int checks = 0;
  int failures = 0;
  int cycleCnt = 0;
  int enCycle = 0;
  logic [5:0] gAddr;
  logic       gRw;
  logic [7:0] gWdata;

  ulpi_reg_seq dut (
    .CLK_60M    (CLK_60M),
    .RST_USB    (RST_USB),
    .ULPI_READY (ULPI_READY),
    .REG_EN     (REG_EN),
    .REG_RW     (REG_RW),
    .REG_ADDR   (REG_ADDR),
    .REG_WDATA  (REG_WDATA),
    .REG_RDATA  (REG_RDATA),
    .REG_DONE   (REG_DONE),
    .REG_FAIL   (REG_FAIL),
    .REQ_EN     (REQ_EN),
    .REQ_RW     (REQ_RW),
    .REQ_ADDR   (REQ_ADDR),
    .REQ_WDATA  (REQ_WDATA),
    .REQ_DONE   (REQ_DONE),
    .REQ_ERR    (REQ_ERR),
    .REQ_RDATA  (REQ_RDATA),
    .INIT_DONE  (INIT_DONE),
    .INIT_ERR   (INIT_ERR)
  );

  // 60 MHz-style free-running clock
  always #5 CLK_60M = ~CLK_60M;

  // Cycle counter used to measure spacing between strobes
  always @(posedge CLK_60M) cycleCnt <= cycleCnt + 1;

  // Hard stop in case something outside the bounded waits hangs
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(negedge CLK_60M);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] en, input logic [1:0] rw,
                               input logic [11:0] addr, input logic [15:0] wdata);
    REQ_EN    = en;
    REQ_RW    = rw;
    REQ_ADDR  = addr;
    REQ_WDATA = wdata;
  endtask

  task automatic resetDut();
    RST_USB    = 1'b1;
    ULPI_READY = 1'b1;
    repeat (2) tick();
    RST_USB = 1'b0;
  endtask

  task automatic waitRegEn(input int limit, output bit found);
    int waited = 0;
    while (REG_EN !== 1'b1 && waited < limit) begin
      tick();
      waited++;
    end
    found = (REG_EN === 1'b1);
  endtask

  // resp: 0 = REG_DONE, 1 = REG_FAIL, 2 = silent
  task automatic serveAccess(input int resp, input logic [7:0] rdata);
    bit found;
    waitRegEn(600, found);
    checkOutput("reg_en_seen", 32'(found), 32'd1);
    gAddr   = REG_ADDR;
    gRw     = REG_RW;
    gWdata  = REG_WDATA;
    enCycle = cycleCnt;
    tick();
    if (resp == 0) begin
      REG_DONE  = 1'b1;
      REG_RDATA = rdata;
    end else if (resp == 1) begin
      REG_FAIL = 1'b1;
    end
    tick();
    REG_DONE  = 1'b0;
    REG_FAIL  = 1'b0;
    REG_RDATA = 8'h00;
  endtask

  task automatic bootStep(input int idx, input int resp, input logic [7:0] rdata);
    logic [14:0] exp;
    case (idx)
      0:       exp = {1'b1, 6'h04, 8'h20};
      1:       exp = {1'b1, 6'h04, 8'h45};
      2:       exp = {1'b1, 6'h0A, 8'h00};
      default: exp = {1'b0, 6'h04, 8'h00};
    endcase
    serveAccess(resp, rdata);
    checkOutput($sformatf("boot_step%0d_access", idx),
                32'({gRw, gAddr, (gRw ? gWdata : 8'h00)}), 32'(exp));
  endtask

  task automatic countRegEn(input int n, output int cnt, output logic [1:0] pulses);
    cnt = 0;
    pulses = 2'b00;
    for (int i = 0; i < n; i++) begin
      tick();
      if (REG_EN === 1'b1) cnt++;
      pulses = pulses | REQ_DONE | REQ_ERR;
    end
  endtask

  initial begin
    int         cnt;
    int         prevEn;
    logic [1:0] pulses;

    RST_USB    = 1'b1;
    ULPI_READY = 1'b0;
    REG_RDATA  = 8'h00;
    REG_DONE   = 1'b0;
    REG_FAIL   = 1'b0;
    applyStimulus(2'b00, 2'b00, 12'h000, 16'h0000);
    repeat (3) tick();
    checkOutput("reset_outputs",
                32'({REG_EN, REG_RW, REG_ADDR, REG_WDATA, REQ_DONE, REQ_ERR,
                     REQ_RDATA, INIT_DONE, INIT_ERR}), 32'd0);

    // Boot with requester 1 already asking for a read of 0x17
    $display("[TB] boot with early request");
    applyStimulus(2'b10, 2'b00, {6'h17, 6'h16}, 16'h0000);
    RST_USB    = 1'b0;
    ULPI_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bootStep(i, 0, (i == 3) ? 8'h45 : 8'h00);
      if (i == 0) begin
        ULPI_READY = 1'b0;
        repeat (3) tick();
        ULPI_READY = 1'b1;
      end
    end
    checkOutput("init_done_not_early", 32'(INIT_DONE), 32'd0);
    tick();
    checkOutput("init_done", 32'({INIT_DONE, INIT_ERR}), 32'b10);

    serveAccess(0, 8'hB7);
    checkOutput("early_req_access", 32'({gRw, gAddr}), 32'({1'b0, 6'h17}));
    checkOutput("early_req_done", 32'(REQ_DONE), 32'b10);
    checkOutput("early_req_rdata", 32'(REQ_RDATA), 32'hB7);
    applyStimulus(2'b00, 2'b00, 12'h000, 16'h0000);
    tick();
    checkOutput("req_done_one_cycle", 32'(REQ_DONE), 32'd0);
    countRegEn(20, cnt, pulses);
    checkOutput("early_req_served_once", 32'(cnt), 32'd0);

    // Both requesters reading: grants must alternate 0, 1, 0, 1
    $display("[TB] round-robin arbitration");
    applyStimulus(2'b11, 2'b00, {6'h17, 6'h16}, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      serveAccess(0, 8'hA0 + 8'(i));
      checkOutput($sformatf("rr_grant%0d_addr", i), 32'(gAddr), (i % 2 == 0) ? 32'h16 : 32'h17);
      checkOutput($sformatf("rr_grant%0d_done", i), 32'(REQ_DONE), (i % 2 == 0) ? 32'b01 : 32'b10);
      checkOutput($sformatf("rr_grant%0d_rdata", i), 32'(REQ_RDATA), 32'hA0 + i);
    end
    applyStimulus(2'b00, 2'b00, 12'h000, 16'h0000);
    tick();

    // Requester write: REQ_RDATA is forced to zero
    $display("[TB] requester write and error");
    applyStimulus(2'b01, 2'b01, {6'h00, 6'h0A}, {8'h00, 8'h5A});
    serveAccess(0, 8'hFF);
    checkOutput("wr_access", 32'({gRw, gAddr, gWdata}), 32'({1'b1, 6'h0A, 8'h5A}));
    checkOutput("wr_done_rdata", 32'({REQ_DONE, REQ_RDATA}), 32'({2'b01, 8'h00}));
    applyStimulus(2'b00, 2'b00, 12'h000, 16'h0000);
    tick();

    // Three aborts in a row turn into a requester error
    applyStimulus(2'b01, 2'b01, {6'h00, 6'h0A}, {8'h00, 8'h5A});
    for (int i = 0; i < 3; i++) serveAccess(1, 8'h00);
    checkOutput("req_err_pulse", 32'({REQ_ERR, REQ_DONE}), 32'({2'b01, 2'b00}));
    applyStimulus(2'b00, 2'b00, 12'h000, 16'h0000);
    countRegEn(10, cnt, pulses);
    checkOutput("req_err_no_more_retry", 32'(cnt), 32'd0);

    // Reset while a requester access waits for the PHY
    $display("[TB] reset mid-access");
    applyStimulus(2'b01, 2'b01, {6'h00, 6'h0A}, {8'h00, 8'h33});
    begin
      bit found;
      waitRegEn(50, found);
      checkOutput("midreset_access_issued", 32'({found, REG_ADDR}), 32'({1'b1, 6'h0A}));
    end
    repeat (3) tick();
    RST_USB    = 1'b1;
    ULPI_READY = 1'b0;
    applyStimulus(2'b00, 2'b00, 12'h000, 16'h0000);
    tick();
    RST_USB = 1'b0;
    countRegEn(4, cnt, pulses);
    checkOutput("midreset_no_pulse", 32'(pulses), 32'd0);
    checkOutput("midreset_init_cleared", 32'({INIT_DONE, INIT_ERR}), 32'd0);
    ULPI_READY = 1'b1;

    // Boot restarts at step 0; step 1 aborted twice, then succeeds
    $display("[TB] boot restart with retries");
    bootStep(0, 0, 8'h00);
    bootStep(1, 1, 8'h00);
    bootStep(1, 1, 8'h00);
    bootStep(1, 0, 8'h00);
    bootStep(2, 0, 8'h00);
    bootStep(3, 0, 8'h45);
    tick();
    checkOutput("retry_boot_done", 32'({INIT_DONE, INIT_ERR}), 32'b10);

    // Step 1 aborted on every attempt: boot fails and stays failed
    $display("[TB] boot retry exhaustion");
    resetDut();
    bootStep(0, 0, 8'h00);
    for (int i = 0; i < 3; i++) bootStep(1, 1, 8'h00);
    checkOutput("retry_exhaust_err", 32'({INIT_DONE, INIT_ERR}), 32'b01);
    applyStimulus(2'b01, 2'b00, {6'h00, 6'h16}, 16'h0000);
    countRegEn(30, cnt, pulses);
    checkOutput("failed_no_reg_en", 32'(cnt), 32'd0);
    checkOutput("failed_no_req_pulse", 32'(pulses), 32'd0);
    applyStimulus(2'b00, 2'b00, 12'h000, 16'h0000);

    // PHY silent: re-issue 256 cycles after each strobe, error after three
    $display("[TB] timeout");
    resetDut();
    bootStep(0, 2, 8'h00);
    prevEn = enCycle;
    bootStep(0, 2, 8'h00);
    checkOutput("timeout_reissue1_gap", 32'(enCycle - prevEn), 32'd256);
    prevEn = enCycle;
    bootStep(0, 2, 8'h00);
    checkOutput("timeout_reissue2_gap", 32'(enCycle - prevEn), 32'd256);
    countRegEn(260, cnt, pulses);
    checkOutput("timeout_no_fourth", 32'(cnt), 32'd0);
    checkOutput("timeout_init_err", 32'({INIT_DONE, INIT_ERR}), 32'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
